// File: rtl/witf_pkg.sv
// Shared types and defaults for the write-in-flight table.
// The entry struct is the storage format of one in-flight destination register.
package witf_pkg;
    localparam int WITF_DEPTH  = 4;
    localparam int WITF_REG_AW = 5;

    typedef struct packed {
        logic                   valid;
        logic [WITF_REG_AW-1:0] rd;
    } witf_entry_t;
endpackage

// File: rtl/witf_match.sv
// Per-entry comparator: flags a RAW hazard when a used, non-x0 source operand
// names the destination held by a valid in-flight entry.
module witf_match #(
    parameter int REG_AW = witf_pkg::WITF_REG_AW
) (
    input  logic              entry_valid,
    input  logic [REG_AW-1:0] entry_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic              hit
);
    logic hit1;
    logic hit2;

    always_comb begin
        hit1 = rs1_used & (|rs1) & (rs1 == entry_rd);
        hit2 = rs2_used & (|rs2) & (rs2 == entry_rd);
        hit  = entry_valid & (hit1 | hit2);
    end
endmodule

// File: rtl/witf_scoreboard.sv
// Write-in-flight table: records destinations of dispatched register writers,
// retires them in order at writeback and stalls decode on RAW hazards or when full.
module witf_scoreboard
    import witf_pkg::*;
#(
    parameter int DEPTH  = WITF_DEPTH,
    parameter int REG_AW = WITF_REG_AW,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              disp_valid,
    input  logic              disp_regwr,
    input  logic [REG_AW-1:0] disp_rd,
    input  logic              pipeline_flush,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              is_raw,
    output logic              witf_full,
    output logic              witf_empty,
    output logic              disp_stall,
    output logic [CNT_W-1:0]  count,
    output logic              err
);
    localparam int PTR_W = $clog2(DEPTH);

    witf_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q, err_d;
    logic                    push;
    logic                    pop;
    logic [DEPTH-1:0]        hits;

    assign witf_full  = (count_q == CNT_W'(DEPTH));
    assign witf_empty = (count_q == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        witf_match #(.REG_AW(REG_AW)) u_match (
            .entry_valid (entries_q[i].valid),
            .entry_rd    (entries_q[i].rd),
            .rs1         (rs1),
            .rs2         (rs2),
            .rs1_used    (rs1_used),
            .rs2_used    (rs2_used),
            .hit         (hits[i])
        );
    end

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
    always_comb begin
        push      = disp_valid & disp_regwr & (|disp_rd) & ~pipeline_flush & ~witf_full;
        pop       = wb_valid & ~witf_empty;
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;

        if (wb_valid && (witf_empty || (wb_rd != entries_q[rd_ptr_q].rd))) begin
            err_d = 1'b1;
        end
        if (pop) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            entries_d[wr_ptr_q].valid = 1'b1;
            entries_d[wr_ptr_q].rd    = disp_rd;
            wr_ptr_d                  = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    // No writeback bypass: the entry retiring this cycle still raises the hazard.
    always_comb begin
        is_raw     = |hits;
        disp_stall = is_raw | witf_full;
        count      = count_q;
        err        = err_q;
    end
endmodule
